// File: rtl/ctrl_pipe.sv
// ID/EX -> EX/MEM -> MEM/WB control pipeline with bubble insertion, IF/ID flush and EX forwarding selects.
// Define CTRL_PIPE_HAZARD_EN to enable load-use stall detection; otherwise loads need software delay slots.
module ctrl_pipe #(
    parameter logic [4:0] RA_REG = 5'd31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_RegDst,
    input  logic       id_Jump,
    input  logic       id_Branch,
    input  logic       id_MemRead,
    input  logic       id_MemtoReg,
    input  logic       id_MemWrite,
    input  logic       id_ALUSrc,
    input  logic       id_RegWrite,
    input  logic       id_JAL,
    input  logic [1:0] id_ALUOp,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_rd,
    input  logic       ex_br_taken,
    output logic       stall,
    output logic       ifid_flush,
    output logic       ex_ALUSrc,
    output logic       ex_MemRead,
    output logic       ex_MemWrite,
    output logic       ex_MemtoReg,
    output logic       ex_RegWrite,
    output logic       ex_Branch,
    output logic       ex_JAL,
    output logic [1:0] ex_ALUOp,
    output logic [4:0] ex_rs,
    output logic [4:0] ex_rt,
    output logic [4:0] ex_dest,
    output logic       mem_MemRead,
    output logic       mem_MemWrite,
    output logic       mem_MemtoReg,
    output logic       mem_RegWrite,
    output logic       mem_JAL,
    output logic [4:0] mem_dest,
    output logic       wb_MemtoReg,
    output logic       wb_RegWrite,
    output logic       wb_JAL,
    output logic [4:0] wb_dest,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    typedef struct packed {
        logic       aluSrc;
        logic       memRead;
        logic       memWrite;
        logic       memtoReg;
        logic       regWrite;
        logic       branch;
        logic       jal;
        logic [1:0] aluOp;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
    } idExT;

    idExT       idBundle;
    idExT       exBundle;
    logic [4:0] idDest;
    logic       hz;

    // RegDst is stale for j/jal/sw/beq; harmless since dest only matters with RegWrite set.
    assign idDest = id_JAL ? RA_REG : (id_RegDst ? id_rd : id_rt);

`ifdef CTRL_PIPE_HAZARD_EN
    // rt is compared even for I-type consumers: occasionally one extra stall, never a missed one.
    assign hz = ex_MemRead & (ex_dest != 5'd0) & ((ex_dest == id_rs) | (ex_dest == id_rt));
`else
    assign hz = 1'b0;
`endif

    assign stall      = hz & ~ex_br_taken;
    assign ifid_flush = ex_br_taken | (id_Jump & ~hz);

    assign idBundle = '{
        aluSrc:   id_ALUSrc,
        memRead:  id_MemRead,
        memWrite: id_MemWrite,
        memtoReg: id_MemtoReg,
        regWrite: id_RegWrite,
        branch:   id_Branch,
        jal:      id_JAL,
        aluOp:    id_ALUOp,
        rs:       id_rs,
        rt:       id_rt,
        dest:     idDest
    };

    // A taken branch or a load-use hazard both turn the ID/EX load into an all-zero bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exBundle <= '0;
        end else if (ex_br_taken || hz) begin
            exBundle <= '0;
        end else begin
            exBundle <= idBundle;
        end
    end

    assign ex_ALUSrc   = exBundle.aluSrc;
    assign ex_MemRead  = exBundle.memRead;
    assign ex_MemWrite = exBundle.memWrite;
    assign ex_MemtoReg = exBundle.memtoReg;
    assign ex_RegWrite = exBundle.regWrite;
    assign ex_Branch   = exBundle.branch;
    assign ex_JAL      = exBundle.jal;
    assign ex_ALUOp    = exBundle.aluOp;
    assign ex_rs       = exBundle.rs;
    assign ex_rt       = exBundle.rt;
    assign ex_dest     = exBundle.dest;

    // Later stages never stall; $0 writes are dropped here so forwarding never matches register 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_MemRead  <= 1'b0;
            mem_MemWrite <= 1'b0;
            mem_MemtoReg <= 1'b0;
            mem_RegWrite <= 1'b0;
            mem_JAL      <= 1'b0;
            mem_dest     <= 5'd0;
            wb_MemtoReg  <= 1'b0;
            wb_RegWrite  <= 1'b0;
            wb_JAL       <= 1'b0;
            wb_dest      <= 5'd0;
        end else begin
            mem_MemRead  <= ex_MemRead;
            mem_MemWrite <= ex_MemWrite;
            mem_MemtoReg <= ex_MemtoReg;
            mem_RegWrite <= ex_RegWrite & (ex_dest != 5'd0);
            mem_JAL      <= ex_JAL;
            mem_dest     <= ex_dest;
            wb_MemtoReg  <= mem_MemtoReg;
            wb_RegWrite  <= mem_RegWrite & (mem_dest != 5'd0);
            wb_JAL       <= mem_JAL;
            wb_dest      <= mem_dest;
        end
    end

    logic [1:0][4:0] exSrc;
    logic [1:0][1:0] fwdSel;

    assign exSrc = {ex_rt, ex_rs};

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign fwdSel[gi] = (mem_RegWrite && (mem_dest == exSrc[gi])) ? 2'b10 :
                            (wb_RegWrite  && (wb_dest  == exSrc[gi])) ? 2'b01 : 2'b00;
    end

    assign fwd_a = fwdSel[0];
    assign fwd_b = fwdSel[1];

endmodule
